// File: rtl/slowmem_pkg.sv
// rtl/slowmem_pkg.sv - shared types and constants for the slow-memory controller
package slowmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WORD_W          = 16;
  localparam int DEFAULT_LATENCY = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-request round-robin arbiter, pointer register kept by the parent
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);

  // On a tie the port that was not granted last wins; otherwise the lone requester wins.
  always_comb begin
    any = |req;
    gnt = 1'b0;
    if (req == 2'b11) gnt = ~last;
    else              gnt = req[1];
  end

endmodule

// File: rtl/slowmem_ctrl.sv
// rtl/slowmem_ctrl.sv - two-port multi-cycle backing store serving cache fills and write-backs
module slowmem_ctrl
  import slowmem_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = DEFAULT_LATENCY,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [WORD_W-1:0] addr0,
  input  logic [WORD_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  output logic [WORD_W-1:0] rdata0,
  output logic [WORD_W-1:0] rdata1,
  output logic              done0,
  output logic              done1,
  output logic              busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  reg [WORD_W-1:0] mem [0:MEM_WORDS-1];

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              last;
  logic              gnt_q;
  logic              wr_q;
  logic [AW-1:0]     addr_q;
  logic [WORD_W-1:0] wdata_q;

  logic gnt;
  logic any;

  // Address bits above the array index are deliberately dropped (address wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^{addr0, addr1};

  rr_arbiter2 u_arb (
    .req  ({req1, req0}),
    .last (last),
    .gnt  (gnt),
    .any  (any)
  );

  logic access_now;
  assign access_now = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            gnt_q   <= gnt;
            last    <= gnt;
            wr_q    <= gnt ? wr1 : wr0;
            addr_q  <= gnt ? addr1[AW-1:0] : addr0[AW-1:0];
            wdata_q <= gnt ? wdata1 : wdata0;
            cnt     <= CW'(LATENCY - 1);
            busy    <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (!wr_q) begin
              if (gnt_q) rdata1 <= mem[addr_q];
              else       rdata0 <= mem[addr_q];
            end
            done0 <= ~gnt_q;
            done1 <= gnt_q;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // Bubble cycle: gives the requester time to drop req after done.
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; a write caught by reset is simply never committed.
  always_ff @(posedge clk) begin
    if (reset && access_now && wr_q) mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_slowmem_ctrl.sv
// tb/tb_slowmem_ctrl.sv - scoreboard bench for slowmem_ctrl
module tb_slowmem_ctrl;

  localparam int L  = 4;
  localparam int MW = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [15:0] rdata0, rdata1;
  logic        done0, done1, busy;

  slowmem_ctrl #(.MEM_WORDS(MW), .LATENCY(L), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0), .rdata1(rdata1), .done0(done0), .done1(done1), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [15:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] mdl [MW];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int port, input logic wr, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.rd   = !wr;
    e.data = mdl[a[7:0]];
    if (wr) mdl[a[7:0]] = d;
    if (port == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic set_port(input int port, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d);
    if (port == 0) begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; end
    else           begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic access(input int port, input logic wr, input logic [15:0] a, input logic [15:0] d);
    bit seen;
    @(negedge clk);
    set_port(port, 1'b1, wr, a, d);
    push(port, wr, a, d);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if ((port == 0 && done0) || (port == 1 && done1)) seen = 1;
    end
    set_port(port, 1'b0, 1'b0, a, d);
    if (!seen) check("access_timeout", 0, 1);
  endtask

  task automatic run_pair(output int k0, output int k1);
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 16'd10, 16'd0);
    set_port(1, 1'b1, 1'b0, 16'd11, 16'd0);
    push(0, 1'b0, 16'd10, 16'd0);
    push(1, 1'b0, 16'd11, 16'd0);
    k0 = -1;
    k1 = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done0 && k0 < 0) begin k0 = k; req0 = 1'b0; end
      if (done1 && k1 < 0) begin k1 = k; req1 = 1'b0; end
      if (k0 >= 0 && k1 >= 0) break;
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Scoreboard: every done pops the oldest expectation for that port.
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) check("done0_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        if (e.rd) check("rdata0", rdata0, e.data);
      end
    end
    if (done1) begin
      if (q1.size() == 0) check("done1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        if (e.rd) check("rdata1", rdata1, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, k1;
    foreach (mdl[i]) mdl[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done0", done0, 0);
    check("rst_done1", done1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    reset = 1'b1;

    // Single read with exact done/busy timing.
    access(0, 1'b1, 16'd5, 16'hBEEF);
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 16'd5, 16'd0);
    push(0, 1'b0, 16'd5, 16'd0);
    for (int k = 0; k <= L + 2; k++) begin
      @(negedge clk);
      check($sformatf("single_busy_k%0d", k), busy, (k <= L));
      check($sformatf("single_done0_k%0d", k), done0, (k == L));
      if (k == L) req0 = 1'b0;
    end
    check("single_rdata0", rdata0, 16'hBEEF);

    // Write through port 1 above MEM_WORDS, read back wrapped through port 0.
    access(1, 1'b1, 16'd260, 16'h1234);
    access(0, 1'b0, 16'd4, 16'd0);
    check("wrap_rdata0", rdata0, 16'h1234);

    // Simultaneous requests straight out of reset, then a repeated tie.
    access(0, 1'b1, 16'd10, 16'hA0A0);
    access(1, 1'b1, 16'd11, 16'hB1B1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_pair(k0, k1);
    check("tie1_done0_k", k0, L);
    check("tie1_done1_k", k1, 2 * L + 2);
    check("tie1_rdata1", rdata1, 16'hB1B1);
    repeat (2) @(negedge clk);
    run_pair(k0, k1);
    check("tie2_done0_k", k0, L);
    check("tie2_done1_k", k1, 2 * L + 2);

    // Held request: re-accepted only after the bubble.
    repeat (2) @(negedge clk);
    set_port(0, 1'b1, 1'b0, 16'd10, 16'd0);
    push(0, 1'b0, 16'd10, 16'd0);
    push(0, 1'b0, 16'd10, 16'd0);
    for (int k = 0; k <= 2 * L + 3; k++) begin
      @(negedge clk);
      if (k == L + 1) check("held_bubble_busy", busy, 0);
      if (k == L + 2) check("held_reaccept_busy", busy, 1);
      check($sformatf("held_done0_k%0d", k), done0, (k == L || k == 2 * L + 2));
      if (k == 2 * L + 2) req0 = 1'b0;
    end

    // Reset during a write aborts it and clears outputs.
    access(0, 1'b1, 16'd7, 16'h0001);
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 16'd7, 16'hAAAA);
    repeat (2) @(negedge clk);
    check("abort_busy_before", busy, 1);
    reset = 1'b0;
    set_port(0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done0", done0, 0);
    check("abort_done1", done1, 0);
    check("abort_rdata0", rdata0, 0);
    check("abort_rdata1", rdata1, 0);
    reset = 1'b1;
    access(0, 1'b0, 16'd7, 16'd0);
    check("abort_readback", rdata0, 16'h0001);

    // Input churn after acceptance must not affect the result.
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 16'd11, 16'd0);
    push(0, 1'b0, 16'd11, 16'd0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done0) break;
      addr0  = 16'($urandom);
      wdata0 = 16'($urandom);
      wr0    = 1'($urandom);
    end
    set_port(0, 1'b0, 1'b0, 16'd0, 16'd0);
    check("churn_rdata0", rdata0, 16'hB1B1);
    access(0, 1'b0, 16'd10, 16'd0);
    check("churn_no_write", rdata0, 16'hA0A0);

    repeat (4) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
